// File: rtl/adder_arbiter_if.sv
// Bundle of requester, shared-adder and result signals for adder_arbiter.
// Latency: none; this file only carries wires.
// Backpressure: res_ready from the consumer stalls the arbiter in DONE.
interface adder_arbiter_if;
  // requester side
  logic        req0;
  logic        req1;
  logic [15:0] x0;
  logic [15:0] x1;
  logic [15:0] y0;
  logic [15:0] y1;
  logic        sub0;
  logic        sub1;
  logic        gnt0;
  logic        gnt1;
  // shared adder side
  logic [15:0] add_x;
  logic [15:0] add_y;
  logic        add_cin;
  logic [15:0] add_s;
  logic        add_cout;
  logic        add_ov;
  // result bus
  logic        res_valid;
  logic        res_id;
  logic [15:0] res_sum;
  logic        res_cout;
  logic        res_ov;
  logic        res_ready;
  // status
  logic        busy;

  // environment: requesters, adder and result consumer
  modport master (
    output req0, req1, x0, x1, y0, y1, sub0, sub1,
    input  gnt0, gnt1,
    input  add_x, add_y, add_cin,
    output add_s, add_cout, add_ov,
    input  res_valid, res_id, res_sum, res_cout, res_ov,
    output res_ready,
    input  busy
  );

  // the arbiter itself
  modport slave (
    input  req0, req1, x0, x1, y0, y1, sub0, sub1,
    output gnt0, gnt1,
    output add_x, add_y, add_cin,
    input  add_s, add_cout, add_ov,
    output res_valid, res_id, res_sum, res_cout, res_ov,
    input  res_ready,
    output busy
  );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for one shared 16-bit adder; ADDER_ARBITER_SUB_EN enables X-Y.
// Latency: gnt in cycle N, res_valid in cycle N+2; issue interval at least 3 cycles.
// Backpressure: result held in DONE until res_ready; requests outside IDLE are ignored.
module adder_arbiter #(
  parameter int START_PRIO = 0
) (
  input logic              clk,
  input logic              rst,
  adder_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic        last_gnt;   // id of the requester granted most recently
  logic [15:0] op_x;
  logic [15:0] op_y;
  logic        op_sub;
  logic        op_id;
  logic [15:0] res_sum_q;
  logic        res_cout_q;
  logic        res_ov_q;
  logic        res_id_q;

  logic        any_req;
  logic        pick1;
  logic [15:0] win_x;
  logic [15:0] win_y;
  logic        sub_sel;

  // Winner selection: a lone request wins, a contended one goes to whoever was not granted last
  always_comb begin
    any_req = bus.req0 | bus.req1;
    pick1   = bus.req1 & (~bus.req0 | ~last_gnt);
    win_x   = pick1 ? bus.x1 : bus.x0;
    win_y   = pick1 ? bus.y1 : bus.y0;
`ifdef ADDER_ARBITER_SUB_EN
    sub_sel = pick1 ? bus.sub1 : bus.sub0;
`else
    // Subtraction compiled out: sub inputs are read but masked so the ports stay wired.
    sub_sel = 1'b0 & (bus.sub0 | bus.sub1);
`endif
  end

  // Grant is decoded in IDLE so the operand capture and the gnt pulse share the same cycle
  assign bus.gnt0 = (state == IDLE) & ~rst & any_req & ~pick1;
  assign bus.gnt1 = (state == IDLE) & ~rst & any_req & pick1;

  // Adder operands come straight from the captured registers; subtraction is X + ~Y + 1
  assign bus.add_x   = op_x;
  assign bus.add_y   = op_sub ? ~op_y : op_y;
  assign bus.add_cin = op_sub;

  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_id    = res_id_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ov    = res_ov_q;

  // Control FSM: capture winner in IDLE, sample adder in ISSUE, hold result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_gnt   <= (START_PRIO == 0);
      op_x       <= '0;
      op_y       <= '0;
      op_sub     <= 1'b0;
      op_id      <= 1'b0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
      res_ov_q   <= 1'b0;
      res_id_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_x     <= win_x;
            op_y     <= win_y;
            op_sub   <= sub_sel;
            op_id    <= pick1;
            last_gnt <= pick1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          res_sum_q  <= bus.add_s;
          res_cout_q <= bus.add_cout;
          res_ov_q   <= bus.add_ov;
          res_id_q   <= op_id;
          state      <= DONE;
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural 16-bit adder on the shared port.
// Latency: checks gnt at N, result at N+2, and the 3-cycle issue spacing.
// Backpressure: exercises res_ready held low in DONE and reset during ISSUE.
module tb_adder_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  adder_arbiter_if bus ();

  adder_arbiter #(.START_PRIO(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared adder: modulo-2^16 sum, carry out and signed overflow
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {16'd0, bus.add_cin};
  assign bus.add_ov = (bus.add_x[15] == bus.add_y[15]) && (bus.add_s[15] != bus.add_x[15]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt0"},  {31'd0, bus.gnt0}, 32'd0);
    chk({tag, "_gnt1"},  {31'd0, bus.gnt1}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd0);
    chk({tag, "_id"},    {31'd0, bus.res_id}, 32'd0);
    chk({tag, "_sum"},   {16'd0, bus.res_sum}, 32'd0);
    chk({tag, "_cout"},  {31'd0, bus.res_cout}, 32'd0);
    chk({tag, "_ov"},    {31'd0, bus.res_ov}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    chk({tag, "_addx"},  {16'd0, bus.add_x}, 32'd0);
    chk({tag, "_addy"},  {16'd0, bus.add_y}, 32'd0);
    chk({tag, "_cin"},   {31'd0, bus.add_cin}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.x0 = 16'h0; bus.y0 = 16'h0; bus.x1 = 16'h0; bus.y1 = 16'h0;
    bus.sub0 = 1'b0; bus.sub1 = 1'b0;
    bus.res_ready = 1'b1;

    // reset with requests and res_ready high: nothing granted, all outputs zero
    tick();
    chk_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();

    // requester 0 alone: 3 + 4
    bus.req0 = 1'b1; bus.x0 = 16'h0003; bus.y0 = 16'h0004;
    #1;
    chk("t1_gnt0", {31'd0, bus.gnt0}, 32'd1);
    chk("t1_gnt1", {31'd0, bus.gnt1}, 32'd0);
    tick();
    bus.req0 = 1'b0;
    chk("t1_gnt0_off", {31'd0, bus.gnt0}, 32'd0);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    chk("t1_valid_n1", {31'd0, bus.res_valid}, 32'd0);
    chk("t1_addx", {16'd0, bus.add_x}, 32'h0003);
    chk("t1_addy", {16'd0, bus.add_y}, 32'h0004);
    chk("t1_cin", {31'd0, bus.add_cin}, 32'd0);
    tick();
    chk("t1_valid_n2", {31'd0, bus.res_valid}, 32'd1);
    chk("t1_sum", {16'd0, bus.res_sum}, 32'h0007);
    chk("t1_id", {31'd0, bus.res_id}, 32'd0);
    chk("t1_cout", {31'd0, bus.res_cout}, 32'd0);
    tick();
    chk("t1_idle", {31'd0, bus.busy}, 32'd0);

    // requester 1 alone: 0xFFFF + 1 wraps to 0 with carry out
    bus.req1 = 1'b1; bus.x1 = 16'hFFFF; bus.y1 = 16'h0001;
    #1;
    chk("t2_gnt1", {31'd0, bus.gnt1}, 32'd1);
    chk("t2_gnt0", {31'd0, bus.gnt0}, 32'd0);
    tick();
    bus.req1 = 1'b0;
    tick();
    chk("t2_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("t2_sum", {16'd0, bus.res_sum}, 32'h0000);
    chk("t2_cout", {31'd0, bus.res_cout}, 32'd1);
    chk("t2_ov", {31'd0, bus.res_ov}, 32'd0);
    chk("t2_id", {31'd0, bus.res_id}, 32'd1);
    tick();

    // both requesting from reset: grants alternate 0,1,0,1 every 3 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0 = 1'b1; bus.x0 = 16'h0010; bus.y0 = 16'h0020;
    bus.req1 = 1'b1; bus.x1 = 16'h1000; bus.y1 = 16'h0100;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("t3_gnt0_c%0d", i), {31'd0, bus.gnt0}, {31'd0, (i % 6) == 0});
      chk($sformatf("t3_gnt1_c%0d", i), {31'd0, bus.gnt1}, {31'd0, (i % 6) == 3});
      if ((i % 6) == 2) begin
        chk($sformatf("t3_sum_c%0d", i), {16'd0, bus.res_sum}, 32'h0030);
        chk($sformatf("t3_id_c%0d", i), {31'd0, bus.res_id}, 32'd0);
      end
      if ((i % 6) == 5) begin
        chk($sformatf("t3_sum_c%0d", i), {16'd0, bus.res_sum}, 32'h1100);
        chk($sformatf("t3_id_c%0d", i), {31'd0, bus.res_id}, 32'd1);
      end
      tick();
    end

    // requester 0 with sub0=1: 5 - 3 when subtraction is built in, 5 + 3 otherwise
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.x0 = 16'h0005; bus.y0 = 16'h0003; bus.sub0 = 1'b1;
    #1;
    chk("t4_gnt0", {31'd0, bus.gnt0}, 32'd1);
    tick();
    bus.req0 = 1'b0; bus.sub0 = 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
    chk("t4_addy", {16'd0, bus.add_y}, 32'h0000FFFC);
    chk("t4_cin", {31'd0, bus.add_cin}, 32'd1);
`else
    chk("t4_addy", {16'd0, bus.add_y}, 32'h00000003);
    chk("t4_cin", {31'd0, bus.add_cin}, 32'd0);
`endif
    tick();
`ifdef ADDER_ARBITER_SUB_EN
    chk("t4_sum", {16'd0, bus.res_sum}, 32'h0002);
    chk("t4_cout", {31'd0, bus.res_cout}, 32'd1);
`else
    chk("t4_sum", {16'd0, bus.res_sum}, 32'h0008);
    chk("t4_cout", {31'd0, bus.res_cout}, 32'd0);
`endif
    chk("t4_ov", {31'd0, bus.res_ov}, 32'd0);
    tick();

    // backpressure: result held 4 cycles with res_ready low, req1 not granted meanwhile
    bus.res_ready = 1'b0;
    bus.req0 = 1'b1; bus.x0 = 16'h1234; bus.y0 = 16'h1111;
    #1;
    chk("t5_gnt0", {31'd0, bus.gnt0}, 32'd1);
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.x1 = 16'h0001; bus.y1 = 16'h0002;
    #1;
    chk("t5_gnt1_issue", {31'd0, bus.gnt1}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t5_valid_k%0d", k), {31'd0, bus.res_valid}, 32'd1);
      chk($sformatf("t5_sum_k%0d", k), {16'd0, bus.res_sum}, 32'h2345);
      chk($sformatf("t5_gnt1_k%0d", k), {31'd0, bus.gnt1}, 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("t5_valid_acc", {31'd0, bus.res_valid}, 32'd1);
    chk("t5_gnt1_acc", {31'd0, bus.gnt1}, 32'd0);
    tick();
    #1;
    chk("t5_gnt1_after", {31'd0, bus.gnt1}, 32'd1);
    tick();
    bus.req1 = 1'b0;
    tick();
    chk("t5_sum1", {16'd0, bus.res_sum}, 32'h0003);
    chk("t5_id1", {31'd0, bus.res_id}, 32'd1);
    tick();

    // reset pulsed during ISSUE discards the operation
    bus.req0 = 1'b1; bus.x0 = 16'h00FF; bus.y0 = 16'h0001;
    #1;
    chk("t6_gnt0", {31'd0, bus.gnt0}, 32'd1);
    tick();
    bus.req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_busy_issue", {31'd0, bus.busy}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk_all_zero("t6_post");
    tick();
    chk("t6_valid_a", {31'd0, bus.res_valid}, 32'd0);
    tick();
    chk("t6_valid_b", {31'd0, bus.res_valid}, 32'd0);
    chk("t6_busy_b", {31'd0, bus.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
